// File: rtl/memory_8x8_march_bist.sv
// March C- self-test controller for an 8x8 sync-write, comb-read memory.
// Ports: clk, reset (async low), start, mem_* bus, busy/done/pass/fail, fail_*.
module memory_8x8_march_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = 1;

  state_t            state;
  logic [2:0]        elem;
  logic [ADDR_W-1:0] addr;
  logic              phase;

  logic              down;
  logic              two_op;
  logic              is_read;
  logic              last_addr;
  logic              op_last;
  logic              elem_last;
  logic              mismatch;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] wr_word;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    down      = (elem == 3'd3) || (elem == 3'd4);
    two_op    = (elem != 3'd0) && (elem != 3'd5);
    is_read   = (elem == 3'd5) || (two_op && !phase);
    exp_word  = {DATA_W{(elem == 3'd2) || (elem == 3'd4)}};
    wr_word   = {DATA_W{(elem == 3'd1) || (elem == 3'd3)}};
    last_addr = down ? (addr == '0) : (addr == '1);
    op_last   = two_op ? phase : 1'b1;
    elem_last = op_last && last_addr;
    step_addr = down ? addr - A_ONE : addr + A_ONE;
    // Where the sweep direction flips the next
    // element starts on the address just visited.
    if (elem_last && ((elem == 3'd2) || (elem == 3'd4)))
      next_addr = addr;
    else
      next_addr = step_addr;
    mismatch = (state == S_RUN) && is_read &&
               (mem_rdata != exp_word);
  end

  always_comb begin
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    mem_addr  = busy ? addr : '0;
    mem_we    = busy && !is_read;
    mem_wdata = mem_we ? wr_word : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      elem          <= '0;
      addr          <= '0;
      phase         <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_RUN;
            elem          <= '0;
            addr          <= '0;
            phase         <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
          end
        end
        S_RUN: begin
          if (mismatch) begin
            state         <= S_DONE;
            fail          <= 1'b1;
            fail_addr     <= addr;
            fail_expected <= exp_word;
            fail_actual   <= mem_rdata;
          end else if (elem == 3'd5 && last_addr) begin
            state <= S_DONE;
            pass  <= 1'b1;
          end else begin
            phase <= two_op && !phase;
            if (op_last)
              addr <= next_addr;
            if (elem_last)
              elem <= elem + 3'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_8x8_march_bist.sv
// Bench for memory_8x8_march_bist: fault-injectable memory plus
// an op-list reference model compared against the DUT every cycle.
module tb_memory_8x8_march_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, pass, fail;
  logic [2:0] fail_addr;
  logic [7:0] fail_expected, fail_actual;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_8x8_march_bist #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail(fail),
    .fail_addr(fail_addr),
    .fail_expected(fail_expected),
    .fail_actual(fail_actual)
  );

  // memory under test with optional faults
  logic       fault_shift = 1'b0;
  logic       sa_en = 1'b0;
  logic [2:0] sa_addr = '0;
  int         sa_bit = 0;
  logic       sa_val = 1'b0;
  logic [7:0] bmem [8];

  always @(posedge clk)
    if (mem_we) bmem[mem_addr] <= mem_wdata;

  always_comb begin
    logic [2:0] ra;
    logic [7:0] w;
    ra = fault_shift ? mem_addr + 3'd1 : mem_addr;
    w  = bmem[ra];
    if (sa_en && mem_addr == sa_addr) w[sa_bit] = sa_val;
    mem_rdata = w;
  end

  function automatic logic [2:0] src(input logic [2:0] a);
    return fault_shift ? a + 3'd1 : a;
  endfunction

  function automatic logic [7:0] xform(input logic [2:0] a,
                                       input logic [7:0] w);
    logic [7:0] r;
    r = w;
    if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: flat list of March C- operations
  typedef struct {
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
  } op_t;
  op_t ops[$];

  task automatic add(input logic we, input int a, input logic [7:0] d);
    op_t o;
    o.we = we;
    o.a  = 3'(a);
    o.d  = d;
    ops.push_back(o);
  endtask

  task automatic build_ops();
    for (int a = 0; a < 8; a++) add(1, a, 8'h00);
    for (int a = 0; a < 8; a++) begin add(0, a, 8'h00); add(1, a, 8'hFF); end
    for (int a = 0; a < 8; a++) begin add(0, a, 8'hFF); add(1, a, 8'h00); end
    for (int a = 7; a >= 0; a--) begin add(0, a, 8'h00); add(1, a, 8'hFF); end
    for (int a = 7; a >= 0; a--) begin add(0, a, 8'hFF); add(1, a, 8'h00); end
    for (int a = 0; a < 8; a++) add(0, a, 8'h00);
  endtask

  int         m_state = 0;
  int         m_idx = 0;
  logic       m_pass = 0, m_fail = 0;
  logic [2:0] m_fa = 0;
  logic [7:0] m_fe = 0, m_fx = 0;
  logic [7:0] mm [8];

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_state = 0; m_idx = 0; m_pass = 0; m_fail = 0;
      m_fa = 0; m_fe = 0; m_fx = 0;
    end else begin
      case (m_state)
        0: if (start) begin
          m_state = 1; m_idx = 0; m_pass = 0; m_fail = 0;
          m_fa = 0; m_fe = 0; m_fx = 0;
        end
        1: begin
          op_t        o;
          logic [7:0] v;
          bit         adv;
          o   = ops[m_idx];
          adv = 1;
          if (o.we) mm[o.a] = o.d;
          else begin
            v = xform(o.a, mm[src(o.a)]);
            if (v !== o.d) begin
              m_fail = 1; m_fa = o.a; m_fe = o.d; m_fx = v;
              m_state = 2; adv = 0;
            end
          end
          if (adv) begin
            m_idx++;
            if (m_idx == ops.size()) begin m_pass = 1; m_state = 2; end
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [34:0] exp_v, act_v;
    logic [2:0]  ea;
    logic        ew;
    logic [7:0]  ed;
    ea = 0; ew = 0; ed = 0;
    if (m_state == 1) begin
      ea = ops[m_idx].a;
      ew = ops[m_idx].we;
      ed = ew ? ops[m_idx].d : 8'h00;
    end
    exp_v = {ea, ew, ed, m_state == 1, m_state == 2, m_pass, m_fail,
             m_fa, m_fe, m_fx};
    act_v = {mem_addr, mem_we, mem_wdata, busy, done, pass, fail,
             fail_addr, fail_expected, fail_actual};
    chk("cycle", 64'(act_v), 64'(exp_v));
  end

  task automatic kick();
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_run(output int lat, output int bc);
    kick();
    lat = 0;
    bc  = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) break;
    end
    if (!done) chk("run_timeout", 64'(done), 64'd1);
  endtask

  int lat, bc, ndone;

  initial begin
    build_ops();
    chk("ops_len", 64'(ops.size()), 64'd80);
    chk("op22", 64'({ops[22].we, ops[22].a, ops[22].d}), 64'h0700);
    chk("op34", 64'({ops[34].we, ops[34].a, ops[34].d}), 64'h05FF);
    chk("op40", 64'({ops[40].we, ops[40].a, ops[40].d}), 64'h0700);
    chk("op79", 64'({ops[79].we, ops[79].a, ops[79].d}), 64'h0700);

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({mem_addr, mem_we, busy, done, pass, fail}), 64'd0);
    #1 reset = 1'b1;

    // good memory
    do_run(lat, bc);
    chk("good_latency", 64'(lat), 64'd81);
    chk("good_busy", 64'(bc), 64'd80);
    chk("good_pf", 64'({pass, fail}), 64'b10);

    // read returns mem[addr+1]
    fault_shift = 1'b1;
    do_run(lat, bc);
    chk("shift_latency", 64'(lat), 64'd24);
    chk("shift_pf", 64'({pass, fail}), 64'b01);
    chk("shift_info", 64'({fail_addr, fail_expected, fail_actual}),
        64'({3'd7, 8'h00, 8'hFF}));
    fault_shift = 1'b0;

    // mem[5] bit 3 stuck at 0
    sa_en = 1'b1; sa_addr = 3'd5; sa_bit = 3; sa_val = 1'b0;
    do_run(lat, bc);
    chk("stuck_info", 64'({fail_addr, fail_expected, fail_actual}),
        64'({3'd5, 8'hFF, 8'hF7}));
    sa_en = 1'b0;

    // good run after failure
    do_run(lat, bc);
    chk("recover_pf", 64'({pass, fail, fail_addr, fail_actual}),
        64'({2'b10, 3'd0, 8'h00}));

    // reset mid-run at RUN cycle 30
    kick();
    repeat (31) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("async_reset",
           64'({mem_addr, mem_we, mem_wdata, busy, done, pass, fail,
                fail_addr, fail_expected, fail_actual}), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    do_run(lat, bc);
    chk("post_reset", 64'({lat, pass, fail}), 64'({32'd81, 2'b10}));

    // start held high
    @(negedge clk);
    #1 start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 250; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 100) chk("held_pass_clr", 64'(pass), 64'd0);
    end
    #1 start = 1'b0;
    chk("held_runs", 64'(ndone), 64'd3);
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    chk("held_final", 64'({done, pass}), 64'b11);

    // randomized faults, gaps and resets
    for (int r = 0; r < 10; r++) begin
      int mode;
      @(negedge clk);
      mode        = $urandom_range(0, 3);
      fault_shift = (mode == 1);
      sa_en       = (mode >= 2);
      sa_addr     = 3'($urandom_range(0, 7));
      sa_bit      = $urandom_range(0, 7);
      sa_val      = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        kick();
        repeat ($urandom_range(1, 90)) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end else begin
        do_run(lat, bc);
      end
    end
    fault_shift = 1'b0;
    sa_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_8x8_march_bist.md
Name: memory_8x8_march_bist

Overview:
- Built-in self-test controller placed directly upstream of the 8x8 synchronous-write, combinational-read memory.
- Owns the memory's addr/write_enable/data_in during test and consumes its data_out.
- Runs a March C- sequence on start and reports pass/fail plus first-failure address and data.
- Used at startup, and in benches to screen memory variants, including faulty-read ones.

Parameters:
- ADDR_W, 3, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, memory word width; background "0" = all zeros, background "1" = all ones.

Ports:
- clk  input  1  Single clock; all state updates on posedge.
- reset  input  1  Asynchronous, active-low reset.
- start  input  1  Begin test; sampled only in IDLE.
- mem_addr  output  ADDR_W  Address to memory.
- mem_we  output  1  Write enable to memory.
- mem_wdata  output  DATA_W  Write data to memory.
- mem_rdata  input  DATA_W  Memory data_out, combinational on mem_addr.
- busy  output  1  High while the march runs.
- done  output  1  One-cycle pulse when the test ends (pass or abort).
- pass  output  1  Sticky: last test completed clean.
- fail  output  1  Sticky: last test found a mismatch.
- fail_addr  output  ADDR_W  Address of first mismatch.
- fail_expected  output  DATA_W  Expected word at first mismatch.
- fail_actual  output  DATA_W  mem_rdata captured at first mismatch.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0.
  - All outputs 0: mem_addr, mem_we, mem_wdata, busy, done, pass, fail, fail_*.
  - Reset mid-run aborts immediately; mem_we drops asynchronously.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on clk edge with start=1.
  - RUN -> DONE after the last op or on the first mismatch.
  - DONE -> IDLE unconditionally next cycle.
  - done=1 only in DONE.
- Start handling:
  - Entering RUN clears pass, fail and fail_* to 0.
  - start is ignored in RUN and DONE.
  - start held high re-triggers only once back in IDLE.
- Element sequence (one op per cycle, element counter 0..5, address counter, op-phase bit):
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
  - "up" means address 0..7; "down" means 7..0. Address wraps within ADDR_W.
  - Two-op elements do read then write at the same address before the address advances.
- Run length: 8+16+16+16+16+8 = 80 RUN cycles, 40 writes and 40 reads. RUN cycle 0 is the first cycle after start is sampled.
- Memory drive:
  - mem_addr, mem_we and mem_wdata are decoded from registered state and valid for the whole cycle.
  - mem_we=1 only on write ops, with mem_wdata = background.
  - On read ops, mem_we=0 and mem_wdata=0.
  - In IDLE and DONE, mem_we=0 and mem_addr=0.
- Read check:
  - mem_rdata is compared against the expected background in the same cycle as the read op.
  - On mismatch, at that clk edge: fail=1, fail_addr=mem_addr, fail_expected and fail_actual captured, state -> DONE. No further memory ops.
  - Only the first mismatch is recorded.
- Completion: if the last M5 read (addr 7, RUN cycle 79) matches, pass=1 at that edge and state -> DONE.
- busy=1 exactly while in RUN.
- pass and fail are never both 1.
- Latency: start edge to done pulse = 81 cycles for a passing test.

Test Plan:
- Good memory: pulse start -> busy high 80 cycles, mem_addr order 0..7 in M0–M2 and M5, 7..0 in M3/M4, done pulse at cycle 81, pass=1, fail=0.
- Faulty-read memory (data_out = mem[addr+1], 3-bit wrap) -> mismatch at M1 read of addr 7 (RUN cycle 22): fail=1, fail_addr=7, fail_expected=0x00, fail_actual=0xFF, done next cycle, no writes after cycle 22.
- Memory with mem[5] bit 3 stuck at 0 -> first mismatch at M2 read of addr 5 (RUN cycle 34): fail_addr=5, fail_expected=0xFF, fail_actual=0xF7.
- Drop reset at RUN cycle 30 -> all outputs 0 asynchronously, state IDLE. Release, pulse start -> full 80-cycle run ends with pass=1.
- Hold start high continuously -> ignored during RUN/DONE. New run begins the cycle after returning to IDLE. pass clears at that run's entry and reasserts at its end.
- After a failing run, start on a good memory -> fail and fail_* cleared to 0 on RUN entry, run ends with pass=1.
